// File: rtl/ulpi_link_tx_if.sv
// ulpi_link_tx_if: ULPI bus pins plus the link-side packet and register request signals.
// master = link transmitter, slave = PHY pins and packet source.
interface ulpi_link_tx_if;
  logic       DIR;
  logic       NXT;
  logic [7:0] DATA_out;
  logic       DATA_oe;
  logic       STP;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       reg_wr;
  logic [5:0] reg_addr;
  logic [7:0] reg_data;
  logic       reg_busy;
  logic       done;
  logic       abort;

  modport master (
    input  DIR, NXT, tx_data, tx_valid, tx_last,
    input  reg_wr, reg_addr, reg_data,
    output DATA_out, DATA_oe, STP, tx_ready,
    output reg_busy, done, abort
  );

  modport slave (
    output DIR, NXT, tx_data, tx_valid, tx_last,
    output reg_wr, reg_addr, reg_data,
    input  DATA_out, DATA_oe, STP, tx_ready,
    input  reg_busy, done, abort
  );
endinterface

// File: rtl/ulpi_link_tx.sv
// ulpi_link_tx: ULPI link transmitter (TX CMD packets, PHY register writes).
// Define ULPI_TX_CRC_EN to append CRC16 to data-PID packets.
module ulpi_link_tx #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic           clk_ext,
  input logic           rst,
  ulpi_link_tx_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, CMD, DATA, CRC0, CRC1,
    RCMD, RDATA, STOP, DRAIN
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       dir_q, dir_d;
  logic       stp_q, stp_d;
  logic       ff_q, ff_d;
  logic       done_q, done_d;
  logic       abort_q, abort_d;
  logic       busy_q, busy_d;
  logic       is_reg_q, is_reg_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] wdat_q, wdat_d;
  logic       tx_ready;
  logic       waiting;
  logic       tmo;
  logic       crc_pid;
  logic [15:0] crc_out;
  logic [7:0] dout;

  assign tx_ready = (state_q == DRAIN) |
    (!bus.DIR & bus.NXT & bus.tx_valid &
     ((state_q == CMD) | (state_q == DATA)));
  assign waiting = state_q inside {CMD, DATA, CRC0, CRC1, RCMD, RDATA};
  assign tmo = waiting & !bus.NXT &
    (cnt_q == 8'(TIMEOUT - 1));
  assign dir_d = bus.DIR;

`ifdef ULPI_TX_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic        pid_q, pid_d;
  logic        pid_acc, byte_acc;

  function automatic logic [15:0] crc16_upd(
    input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  assign pid_acc  = (state_q == CMD) & tx_ready;
  assign byte_acc = (state_q == DATA) & tx_ready;

  always_comb begin
    crc_d = crc_q;
    pid_d = pid_q;
    if (pid_acc) begin
      crc_d = 16'hFFFF;
      pid_d = (bus.tx_data[1:0] == 2'b11);
    end else if (byte_acc) begin
      crc_d = crc16_upd(crc_q, bus.tx_data);
    end
  end

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      crc_q <= 16'hFFFF;
      pid_q <= 1'b0;
    end else begin
      crc_q <= crc_d;
      pid_q <= pid_d;
    end
  end

  // Data PIDs have both low bits set (0x3, 0x7, 0xB, 0xF).
  assign crc_out = ~crc_q;
  assign crc_pid = (state_q == CMD) ?
    (bus.tx_data[1:0] == 2'b11) : pid_q;
`else
  assign crc_out = 16'h0000;
  assign crc_pid = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    stp_d    = 1'b0;
    ff_d     = 1'b0;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    busy_d   = busy_q;
    is_reg_d = is_reg_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    if (!busy_q && bus.reg_wr) begin
      busy_d = 1'b1;
      addr_d = bus.reg_addr;
      wdat_d = bus.reg_data;
    end
    unique case (state_q)
      IDLE: begin
        if (!bus.DIR && !dir_q) begin
          if (busy_q) begin
            state_d  = RCMD;
            is_reg_d = 1'b1;
          end else if (bus.tx_valid) begin
            state_d  = CMD;
            is_reg_d = 1'b0;
          end
        end
      end
      STOP: begin
        state_d = IDLE;
        if (is_reg_q) busy_d = 1'b0;
      end
      DRAIN: begin
        if (bus.tx_valid && bus.tx_last) state_d = IDLE;
      end
      default: begin
        // PHY grabbed the bus before the command byte was taken: retry later.
        if (bus.DIR) begin
          if (state_q == CMD || state_q == RCMD) begin
            state_d = IDLE;
          end else begin
            abort_d = 1'b1;
            state_d = (state_q == DATA) ? DRAIN : IDLE;
            if (is_reg_q) busy_d = 1'b0;
          end
        end else if (tmo) begin
          abort_d = 1'b1;
          stp_d   = 1'b1;
          ff_d    = 1'b1;
          state_d = (state_q == CMD || state_q == DATA) ? DRAIN : IDLE;
          if (is_reg_q) busy_d = 1'b0;
        end else if (bus.NXT) begin
          unique case (state_q)
            CMD:  state_d = bus.tx_last ? (crc_pid ? CRC0 : STOP) : DATA;
            DATA: begin
              if (bus.tx_valid) begin
                if (bus.tx_last) state_d = crc_pid ? CRC0 : STOP;
              end else begin
                stp_d   = 1'b1;
                ff_d    = 1'b1;
                abort_d = 1'b1;
                state_d = DRAIN;
              end
            end
            CRC0:    state_d = CRC1;
            CRC1:    state_d = STOP;
            RCMD:    state_d = RDATA;
            default: state_d = STOP;
          endcase
        end
      end
    endcase
    if (state_d == STOP && state_q != STOP) begin
      stp_d  = 1'b1;
      done_d = 1'b1;
    end
    if (state_d != state_q || bus.NXT || !waiting) cnt_d = '0;
    else cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dir_q    <= 1'b1;
      stp_q    <= 1'b0;
      ff_q     <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
      is_reg_q <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      stp_q    <= stp_d;
      ff_q     <= ff_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      busy_q   <= busy_d;
      is_reg_q <= is_reg_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
    end
  end

  always_comb begin
    dout = 8'h00;
    unique case (state_q)
      CMD:     dout = {4'b0100, bus.tx_data[3:0]};
      DATA:    dout = bus.tx_data;
      CRC0:    dout = crc_out[7:0];
      CRC1:    dout = crc_out[15:8];
      RCMD:    dout = {2'b10, addr_q};
      RDATA:   dout = wdat_q;
      default: dout = 8'h00;
    endcase
    if (ff_q) dout = 8'hFF;
  end

  // Bus released while PHY drives and for one turnaround cycle after.
  assign bus.DATA_oe  = !bus.DIR & !dir_q;
  assign bus.DATA_out = dout;
  assign bus.STP      = stp_q;
  assign bus.tx_ready = tx_ready;
  assign bus.reg_busy = busy_q;
  assign bus.done     = done_q;
  assign bus.abort    = abort_q;
endmodule
